// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the elastic pipeline-stage register.
//   * default payload widths
//   * occupancy state enum {ST_EMPTY, ST_FULL, ST_SKID}
//   * payload struct at default widths (reference layout for users)
//   * flush_discards(): held entries lost to a flush this cycle
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W = 32;
  localparam int unsigned PIPE_REG_W  = 5;
  localparam int unsigned PIPE_WB_W   = 2;
  localparam int unsigned PIPE_M_W    = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic [PIPE_WB_W-1:0]   wb;
    logic [PIPE_M_W-1:0]    m;
    logic [PIPE_DATA_W-1:0] alu;
    logic [PIPE_DATA_W-1:0] wdata;
    logic [PIPE_REG_W-1:0]  rd;
  } pipe_payload_t;

  // Entries held in a state minus the one leaving downstream this cycle.
  // A draining MAIN entry counts as delivered, not discarded.
  function automatic logic [1:0] flush_discards(input pipe_state_e st, input logic drain);
    logic [1:0] held;
    case (st)
      ST_FULL: held = 2'd1;
      ST_SKID: held = 2'd2;
      default: held = 2'd0;
    endcase
    return held - {1'b0, drain};
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt -- saturating performance counters for pipe_stage_reg.
// Ports:
//   i_clk, i_rst_n     clock, async active-low reset
//   i_stall            count one stall cycle
//   i_flush_add [1:0]  entries discarded by a flush this cycle
//   o_stall_cnt [31:0] stall cycles, saturating
//   o_flush_cnt [15:0] flushed entries, saturating
module pipe_perf_cnt (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic [1:0]  i_flush_add,
  output logic [31:0] o_stall_cnt,
  output logic [15:0] o_flush_cnt
);

  logic [31:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic [16:0] w_flush_sum;

  // One extra bit catches the wrap so the add can clamp instead.
  assign w_flush_sum = {1'b0, r_flush_cnt} + {15'd0, i_flush_add};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (i_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      r_flush_cnt <= w_flush_sum[16] ? '1 : w_flush_sum[15:0];
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- elastic pipeline-stage register with a 2-entry skid
// buffer (MAIN drives the outputs, SKID absorbs one overflow entry), so
// Ready_o is a flop and never depends on Ready_i combinationally.
// Ports:
//   Clock_i, Rst_n_i                 clock, async active-low reset
//   Flush_i                          sync flush, drops all held entries
//   Valid_i / Ready_o                upstream handshake (Ready_o registered)
//   WB_i, M_i, ALU_i, WriteData_i, RegRd_i   payload in
//   Valid_o / Ready_i                downstream handshake
//   WB_o, M_o, ALU_o, WriteData_o, RegRd_o   head-entry payload out
//   StallCnt_o, FlushCnt_o           perf counters, only with PIPE_STAGE_PERF_EN
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned REG_W  = PIPE_REG_W,
  parameter int unsigned WB_W   = PIPE_WB_W,
  parameter int unsigned M_W    = PIPE_M_W
) (
  input  logic              Clock_i,
  input  logic              Rst_n_i,
  input  logic              Flush_i,
  input  logic              Valid_i,
  output logic              Ready_o,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [M_W-1:0]    M_i,
  input  logic [DATA_W-1:0] ALU_i,
  input  logic [DATA_W-1:0] WriteData_i,
  input  logic [REG_W-1:0]  RegRd_i,
  output logic              Valid_o,
  input  logic              Ready_i,
  output logic [WB_W-1:0]   WB_o,
  output logic [M_W-1:0]    M_o,
  output logic [DATA_W-1:0] ALU_o,
  output logic [DATA_W-1:0] WriteData_o,
  output logic [REG_W-1:0]  RegRd_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       StallCnt_o,
  output logic [15:0]       FlushCnt_o
`endif
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  rd;
  } entry_t;

  pipe_state_e r_state, w_state_nxt;
  entry_t      r_main, r_skid, w_in;
  logic        r_ready;
  logic        w_valid, w_accept, w_drain;

  assign w_in     = '{wb: WB_i, m: M_i, alu: ALU_i, wdata: WriteData_i, rd: RegRd_i};
  assign w_valid  = (r_state != ST_EMPTY);
  assign w_accept = Valid_i & r_ready;
  assign w_drain  = w_valid & Ready_i;

  always_comb begin
    w_state_nxt = r_state;
    if (Flush_i) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
        ST_FULL: begin
          if (w_drain && !w_accept)      w_state_nxt = ST_EMPTY;
          else if (w_accept && !w_drain) w_state_nxt = ST_SKID;
        end
        ST_SKID:  if (w_drain) w_state_nxt = ST_FULL;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clock_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      r_state <= ST_EMPTY;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != ST_SKID);
    end
  end

  // MAIN keeps its contents on drain/flush so ALU/WriteData/RegRd hold
  // their last value while the stage is a bubble.
  always_ff @(posedge Clock_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (!Flush_i) begin
      case (r_state)
        ST_EMPTY: if (w_accept) r_main <= w_in;
        ST_FULL: begin
          if (w_accept && w_drain)  r_main <= w_in;
          if (w_accept && !w_drain) r_skid <= w_in;
        end
        ST_SKID:  if (w_drain) r_main <= r_skid;
        default: ;
      endcase
    end
  end

  assign Valid_o     = w_valid;
  assign Ready_o     = r_ready;
  // Bubbles must not write registers or touch memory.
  assign WB_o        = w_valid ? r_main.wb : '0;
  assign M_o         = w_valid ? r_main.m  : '0;
  assign ALU_o       = r_main.alu;
  assign WriteData_o = r_main.wdata;
  assign RegRd_o     = r_main.rd;

`ifdef PIPE_STAGE_PERF_EN
  logic [1:0] w_flush_add;
  assign w_flush_add = Flush_i ? flush_discards(r_state, w_drain) : 2'd0;

  pipe_perf_cnt u_perf (
    .i_clk       (Clock_i),
    .i_rst_n     (Rst_n_i),
    .i_stall     (w_valid & ~Ready_i),
    .i_flush_add (w_flush_add),
    .o_stall_cnt (StallCnt_o),
    .o_flush_cnt (FlushCnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every
// negedge, plus directed scenarios with literal expectations.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, vin = 1'b0, rdy_i = 1'b0;
  logic [1:0]  wb_i = '0, m_i = '0;
  logic [31:0] alu_i = '0, wd_i = '0;
  logic [4:0]  rd_i = '0;
  logic        rdy_o, vld_o;
  logic [1:0]  wb_o, m_o;
  logic [31:0] alu_o, wd_o;
  logic [4:0]  rd_o;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .Clock_i(clk), .Rst_n_i(rst_n), .Flush_i(flush),
    .Valid_i(vin), .Ready_o(rdy_o),
    .WB_i(wb_i), .M_i(m_i), .ALU_i(alu_i), .WriteData_i(wd_i), .RegRd_i(rd_i),
    .Valid_o(vld_o), .Ready_i(rdy_i),
    .WB_o(wb_o), .M_o(m_o), .ALU_o(alu_o), .WriteData_o(wd_o), .RegRd_o(rd_o)
`ifdef PIPE_STAGE_PERF_EN
    , .StallCnt_o(stall_cnt), .FlushCnt_o(flush_cnt)
`endif
  );

  typedef struct packed {
    logic [1:0]  wb;
    logic [1:0]  m;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
  } ent_t;

  // Reference: a FIFO of at most two held entries.
  ent_t        q[$];
  ent_t        last_head = '0;
  logic        m_ready = 1'b1;
  logic [31:0] m_stall = '0;
  logic [15:0] m_flush = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ready   = 1'b1;
      last_head = '0;
      m_stall   = '0;
      m_flush   = '0;
    end else begin
      automatic logic acc = vin & m_ready;
      automatic int   held = q.size();
      if (held > 0 && !rdy_i && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (held > 0 && rdy_i) void'(q.pop_front());
      if (flush) begin
        m_flush = (32'(m_flush) + q.size() > 32'hFFFF) ? 16'hFFFF : m_flush + 16'(q.size());
        q.delete();
      end else if (acc) begin
        q.push_back('{wb: wb_i, m: m_i, alu: alu_i, wd: wd_i, rd: rd_i});
      end
      m_ready = (q.size() < 2);
      if (q.size() > 0) last_head = q[0];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    automatic logic ev = (q.size() > 0);
    chk("valid_o", 64'(vld_o), 64'(ev));
    chk("ready_o", 64'(rdy_o), 64'(m_ready));
    chk("wb_o",    64'(wb_o),  ev ? 64'(q[0].wb) : 64'd0);
    chk("m_o",     64'(m_o),   ev ? 64'(q[0].m)  : 64'd0);
    chk("alu_o",   64'(alu_o), 64'(last_head.alu));
    chk("wdata_o", 64'(wd_o),  64'(last_head.wd));
    chk("regrd_o", 64'(rd_o),  64'(last_head.rd));
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
  end

  // Drive one cycle of inputs; return just after the edge that consumed them.
  task automatic drive(input logic v, input logic r, input logic f, input logic [31:0] a);
    vin   = v;
    rdy_i = r;
    flush = f;
    alu_i = a;
    wb_i  = a[1:0] | 2'b01;
    m_i   = a[2:1] | 2'b10;
    wd_i  = ~a;
    rd_i  = a[4:0] ^ 5'h15;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with Valid_i asserted
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h99);
      chk("rst_valid", 64'(vld_o), 64'd0);
      chk("rst_ready", 64'(rdy_o), 64'd1);
      chk("rst_wb",    64'(wb_o),  64'd0);
      chk("rst_m",     64'(m_o),   64'd0);
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'd0);

    // Back-to-back stream
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(k));
      chk("stream_alu",   64'(alu_o), 64'(k));
      chk("stream_valid", 64'(vld_o), 64'd1);
      chk("stream_ready", 64'(rdy_o), 64'd1);
    end
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("bubble_valid", 64'(vld_o), 64'd0);
    chk("bubble_wb",    64'(wb_o),  64'd0);
    chk("bubble_hold",  64'(alu_o), 64'd4);

    // Skid: A=10 held, B=11 pushed while stalled
    drive(1'b1, 1'b0, 1'b0, 32'd10);
    chk("skid_a", 64'(alu_o), 64'd10);
    drive(1'b1, 1'b0, 1'b0, 32'd11);
    chk("skid_ready0", 64'(rdy_o), 64'd0);
    chk("skid_head",   64'(alu_o), 64'd10);
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("skid_b",      64'(alu_o), 64'd11);
    chk("skid_ready1", 64'(rdy_o), 64'd1);
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("skid_empty",  64'(vld_o), 64'd0);

    // Flush while in SKID with Valid_i high
    drive(1'b1, 1'b0, 1'b0, 32'd20);
    drive(1'b1, 1'b0, 1'b0, 32'd21);
    drive(1'b1, 1'b0, 1'b1, 32'd22);
    chk("flush_valid", 64'(vld_o), 64'd0);
    chk("flush_wb",    64'(wb_o),  64'd0);
    chk("flush_m",     64'(m_o),   64'd0);
    chk("flush_ready", 64'(rdy_o), 64'd1);
    chk("flush_hold",  64'(alu_o), 64'd20);
`ifdef PIPE_STAGE_PERF_EN
    chk("flush_cnt_lit", 64'(flush_cnt), 64'd2);
`endif

    // Stall for 5 cycles with an entry held
    drive(1'b1, 1'b0, 1'b0, 32'd30);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 32'd0);
    chk("stall_head", 64'(alu_o), 64'd30);
`ifdef PIPE_STAGE_PERF_EN
    // 1 (skid) + 2 (flush scenario) + 5 here
    chk("stall_cnt_lit", 64'(stall_cnt), 64'd8);
`endif
    drive(1'b0, 1'b1, 1'b0, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 10000; i++)
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0, $urandom);

    // Reset mid-operation
    drive(1'b1, 1'b0, 1'b0, 32'd40);
    drive(1'b1, 1'b0, 1'b0, 32'd41);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(vld_o), 64'd0);
    chk("midrst_ready", 64'(rdy_o), 64'd1);
    chk("midrst_alu",   64'(alu_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'd50);
    chk("post_rst_alu", 64'(alu_o), 64'd50);
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
